// File: rtl/arith_core_engine.sv
// arith_core_engine: add/sub/umul/smul engine with level-start, sticky-done handshake.
// Defining ARITH_CORE_CYCLE_COUNT_EN adds cyc_count, a saturating count of BUSY cycles.
module arith_core_engine #(
    parameter int WIDTH = 32,
    parameter int MUL_BPC = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               ctl_reset,
    input  logic               ctl_start,
    input  logic [1:0]         ctl_op,
    input  logic [WIDTH-1:0]   data_in1,
    input  logic [WIDTH-1:0]   data_in2,
    output logic [WIDTH-1:0]   data_result_lo,
    output logic [WIDTH-1:0]   data_result_hi,
    output logic               ctl_done,
    output logic               ctl_busy
`ifdef ARITH_CORE_CYCLE_COUNT_EN
    ,
    output logic [15:0]        cyc_count
`endif
);
    localparam int K = WIDTH / MUL_BPC;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic rst, start_q, start_rise, neg;
    logic [1:0] op_q;
    logic [6:0] cnt;
    logic [WIDTH-1:0] mplier, mag1, mag2;
    logic [2*WIDTH-1:0] mcand, acc, pp, prod, res;
    assign rst = reset_reset | ctl_reset;
    assign start_rise = ctl_start & ~start_q;
    // smul runs on magnitudes; the sign is reapplied when the product is written
    assign mag1 = (ctl_op == 2'b11 && data_in1[WIDTH-1]) ? -data_in1 : data_in1;
    assign mag2 = (ctl_op == 2'b11 && data_in2[WIDTH-1]) ? -data_in2 : data_in2;
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_BPC; j++) pp = pp + (mplier[j] ? mcand << j : '0);
    end
    assign prod = acc + pp;
    assign res = op_q[1] ? (neg ? -prod : prod)
               : op_q[0] ? mcand - {{WIDTH{1'b0}}, mplier}
               : mcand + {{WIDTH{1'b0}}, mplier};
    always_ff @(posedge clk_clk) begin
        if (rst) begin
            state <= IDLE;
            start_q <= 1'b1;
            ctl_busy <= 1'b0;
            ctl_done <= 1'b0;
            data_result_lo <= '0;
            data_result_hi <= '0;
        end else begin
            start_q <= ctl_start;
            case (state)
                IDLE: if (start_rise) begin
                    state <= BUSY;
                    ctl_busy <= 1'b1;
                    op_q <= ctl_op;
                    neg <= (ctl_op == 2'b11) && (data_in1[WIDTH-1] ^ data_in2[WIDTH-1]);
                    mcand <= {{WIDTH{1'b0}}, mag1};
                    mplier <= mag2;
                    acc <= '0;
                    cnt <= ctl_op[1] ? 7'(K - 1) : 7'd0;
                end
                BUSY: if (cnt == 7'd0) begin
                    {data_result_hi, data_result_lo} <= res;
                    state <= DONE;
                    ctl_busy <= 1'b0;
                    ctl_done <= 1'b1;
                end else begin
                    cnt <= cnt - 7'd1;
                    acc <= prod;
                    mcand <= mcand << MUL_BPC;
                    mplier <= mplier >> MUL_BPC;
                end
                default: if (!ctl_start) begin
                    state <= IDLE;
                    ctl_done <= 1'b0;
                end
            endcase
        end
    end
`ifdef ARITH_CORE_CYCLE_COUNT_EN
    always_ff @(posedge clk_clk) begin
        if (rst || (state == IDLE && start_rise)) cyc_count <= '0;
        else if (state == BUSY && cyc_count != 16'hFFFF) cyc_count <= cyc_count + 16'd1;
    end
`endif
endmodule

// File: doc/arith_core_engine.md
Name: arith_core_engine

Overview:
- Parametrised FPGA-side arithmetic engine behind the HPS control and data PIO conduits.
- Replaces the separate fixed-width add and mult fabric blocks with one core.
- Supports add, subtract, unsigned multiply and signed multiply, with a level-start / sticky-done handshake.
- The HPS writes the operands and opcode, raises start, polls done, reads the 2*WIDTH result, then drops start.

Parameters:
- WIDTH, 32, operand width in bits; legal values are 8..64.
- MUL_BPC, 1, multiplier bits retired per cycle (1, 2 or 4). WIDTH must be a multiple of MUL_BPC.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous active-high reset.
- ctl_reset  in  1  soft reset from the HPS control conduit; synchronous, same effect as reset_reset.
- ctl_start  in  1  level start from HPS.
- ctl_op  in  2  opcode: 00 add, 01 sub, 10 umul, 11 smul.
- data_in1  in  WIDTH  operand A.
- data_in2  in  WIDTH  operand B.
- data_result_lo  out  WIDTH  result bits [WIDTH-1:0].
- data_result_hi  out  WIDTH  result bits [2*WIDTH-1:WIDTH].
- ctl_done  out  1  result valid (sticky).
- ctl_busy  out  1  operation in progress.

Behaviour:
- Reset (reset_reset or ctl_reset, sampled at posedge):
  - State goes to IDLE.
  - ctl_done=0, ctl_busy=0, result_lo=0, result_hi=0.
  - Start history register start_q=1, so a start held high through reset is not seen as an edge.
  - Reset mid-operation aborts it; no result is written.
- Start detect: start_rise = ctl_start & ~start_q. start_q is registered every cycle.
- FSM IDLE:
  - On start_rise at edge T: capture in1, in2 and op into internal registers, then go to BUSY.
  - Operands may change after T without effect.
- FSM BUSY:
  - ctl_busy=1 for K cycles (T+1..T+K).
  - K=1 for add/sub; K=WIDTH/MUL_BPC for umul/smul.
  - start_rise and any ctl_start change are ignored while BUSY.
  - At the last BUSY edge, result_hi and result_lo are written together, then go to DONE.
- FSM DONE:
  - ctl_done=1 from cycle T+K+1; ctl_busy=0.
  - Leave to IDLE on the first edge where ctl_start=0; ctl_done clears the cycle after.
  - If start was dropped during BUSY, ctl_done is high for exactly one cycle.
- Results hold their value until the next completed operation. They are never cleared except by reset.
- Arithmetic, with {hi,lo} as a 2*WIDTH value:
  - add: in1+in2, operands zero-extended; hi[0]=carry, the rest of hi is 0.
  - sub: in1-in2, operands zero-extended, as a 2*WIDTH two's-complement value; a borrow gives hi all ones.
  - umul: unsigned product.
  - smul: signed two's-complement product. Example: WIDTH=8, 0x80*0x80 = 0x4000.
- Multiplier:
  - Iterative shift-add retiring MUL_BPC bits per cycle; no DSP inference is required.
  - smul may use magnitude multiply plus conditional negate, provided it stays within K cycles.
- New start: a new op requires ctl_start to go low then high again, i.e. through IDLE.
- Simultaneous events: reset wins over everything. A start_rise on the same edge as DONE→IDLE is not possible because start must be 0 to leave DONE.

Optional Feature:
- Macro: ARITH_CORE_CYCLE_COUNT_EN.
- Enabled:
  - Adds output cyc_count (16 bits).
  - It is cleared at the capture edge and increments each BUSY cycle, saturating at 0xFFFF.
  - It holds its value through DONE/IDLE until the next capture; reset value 0.
  - Add/sub reads 1; mult reads WIDTH/MUL_BPC.
- Disabled: the port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, MUL_BPC=1, add 0xFFFFFFFF+0x00000001, start rise at T → busy at T+1, done at T+2, hi=0x00000001, lo=0x00000000.
- sub 5-7 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. Done holds while start=1; done=0 one cycle after start drops.
- umul 0xFFFFFFFF*0xFFFFFFFF → busy 32 cycles, hi=0xFFFFFFFE, lo=0x00000001. smul -3*7 (0xFFFFFFFD, 7) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MUL_BPC=4, WIDTH=16, smul 0x8000*0x8000 → done 5 cycles after capture, {hi,lo}=0x40000000. With the macro on, cyc_count=4.
- Start held high through reset, then released → no operation. Change operands and op mid-BUSY, or toggle start mid-BUSY → result uses the captured values and no second op runs.
- Assert ctl_reset at BUSY cycle 10 of a mult → next cycle IDLE, busy=0, done=0, results=0. A subsequent start runs normally.
